alu_exec_ctrl: RTL and testbench

Execute-stage sequencer for the data-processing ALU.
- Accepts one decoded data-processing instruction at a time over a valid/ready handshake.
- Holds the architectural NZCV flags register and evaluates the instruction condition against it.
- Drives the ALU operands and opcode, captures the result and flags, and presents register writeback over a second valid/ready handshake.
- Sits between the decode stage and the register file write port.

---
 rtl/alu_pkg.sv | 62 ++++++
 rtl/alu_exec_ctrl_cond_eval.sv | 42 ++++
 rtl/alu_exec_ctrl.sv | 163 ++++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage sequencer: condition codes,
// ALU opcodes, sequencer state encoding and NZCV flag bit positions.
package alu_pkg;

  // ARM condition field encodings
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // ALU operation codes
  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_EOR = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_RSB = 5'b00011;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_TST = 5'b01000;
  localparam logic [4:0] OP_TEQ = 5'b01001;
  localparam logic [4:0] OP_CMP = 5'b01010;
  localparam logic [4:0] OP_CMN = 5'b01011;
  localparam logic [4:0] OP_ORR = 5'b01100;
  localparam logic [4:0] OP_MOV = 5'b01101;
  localparam logic [4:0] OP_BIC = 5'b01110;
  localparam logic [4:0] OP_MVN = 5'b01111;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Bit positions inside a {N,Z,C,V} nibble
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Compare ops write flags only, never a register
  function automatic logic is_cmp_op(input logic [4:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

  // Arithmetic ops own the C and V flags; logical ops leave them alone
  function automatic logic is_arith_op(input logic [4:0] op);
    return (op == OP_SUB) || (op == OP_RSB) || (op == OP_ADD) ||
           (op == OP_CMP) || (op == OP_CMN);
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_cond_eval.sv
// Combinational ARM condition evaluator: decides whether an instruction
// with the given condition field executes under the given NZCV flags.
module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = nzcv_i[FLAG_N];
  assign z = nzcv_i[FLAG_Z];
  assign c = nzcv_i[FLAG_C];
  assign v = nzcv_i[FLAG_V];

  // Decode all sixteen condition codes; NV never executes
  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer. Takes one decoded data-processing instruction,
// runs it through the external combinational ALU for one cycle, updates the
// architectural NZCV flags and hands any register result to the write port.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload stable until then; the
// consumer may change ready freely. in_valid/in_ready face decode,
// wb_valid/wb_ready face the register file.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_cond,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_s,
  input  logic [3:0]       in_rd,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [OP_W-1:0]  alu_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_result,
  input  logic [3:0]       alu_nzcv,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [3:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] skipped_cnt,
  output logic [1:0]       dbg_state
);

  state_e            state_q;
  logic [3:0]        cond_q;
  logic              s_q;
  logic [3:0]        rd_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [31:0]       alu_a_q;
  logic [31:0]       alu_b_q;
  logic              in_ready_q;
  logic              wb_valid_q;
  logic [3:0]        wb_rd_q;
  logic [31:0]       wb_data_q;
  logic [3:0]        flags_q;
  logic [3:0]        flags_d;
  logic [CNT_W-1:0]  retired_q;
  logic [CNT_W-1:0]  skipped_q;

  logic pass;
  logic op_supported;
  logic op_cmp;
  logic op_arith;

  cond_eval u_cond_eval (
    .cond_i (cond_q),
    .nzcv_i (flags_q),
    .pass_o (pass)
  );

  // Classify the held opcode and form the candidate new flags
  always_comb begin
    op_supported    = (alu_op_q < OP_W'(16));
    op_cmp          = is_cmp_op(alu_op_q[4:0]);
    op_arith        = is_arith_op(alu_op_q[4:0]);
    flags_d         = flags_q;
    flags_d[FLAG_N] = alu_nzcv[FLAG_N];
    flags_d[FLAG_Z] = alu_nzcv[FLAG_Z];
    if (op_arith) begin
      flags_d[FLAG_C] = alu_nzcv[FLAG_C];
      flags_d[FLAG_V] = alu_nzcv[FLAG_V];
    end
  end

  // Sequencer: accept, execute for one cycle, then optionally write back.
  // The ALU operand registers double as the operand holding registers, so
  // they are loaded on accept and stay frozen until the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cond_q     <= 4'd0;
      s_q        <= 1'b0;
      rd_q       <= 4'd0;
      alu_op_q   <= '0;
      alu_a_q    <= 32'd0;
      alu_b_q    <= 32'd0;
      in_ready_q <= 1'b1;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 4'd0;
      wb_data_q  <= 32'd0;
      flags_q    <= 4'd0;
      retired_q  <= '0;
      skipped_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            cond_q     <= in_cond;
            s_q        <= in_s;
            rd_q       <= in_rd;
            alu_op_q   <= in_op;
            alu_a_q    <= in_a;
            alu_b_q    <= in_b;
            in_ready_q <= 1'b0;
            state_q    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!pass || !op_supported) begin
            skipped_q  <= skipped_q + CNT_W'(1);
            in_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else if (op_cmp) begin
            flags_q    <= flags_d;
            retired_q  <= retired_q + CNT_W'(1);
            in_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            wb_data_q  <= alu_result;
            wb_rd_q    <= rd_q;
            wb_valid_q <= 1'b1;
            if (s_q) begin
              flags_q <= flags_d;
            end
            retired_q  <= retired_q + CNT_W'(1);
            state_q    <= ST_WB;
          end
        end
        ST_WB: begin
          if (wb_ready) begin
            wb_valid_q <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          in_ready_q <= 1'b1;
          wb_valid_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign flags       = flags_q;
  assign retired_cnt = retired_q;
  assign skipped_cnt = skipped_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: behavioural ALU, sequential reference model of
// flags/counters/writebacks, writeback scoreboard, directed plus random runs.
module tb_alu_exec_ctrl;

  localparam int CNT_W = 16;
  localparam int OP_W  = 5;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_cond;
  logic [OP_W-1:0]  in_op;
  logic             in_s;
  logic [3:0]       in_rd;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [OP_W-1:0]  alu_op;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [31:0]      alu_result;
  logic [3:0]       alu_nzcv;
  logic             wb_valid;
  logic             wb_ready = 1'b1;
  logic [3:0]       wb_rd;
  logic [31:0]      wb_data;
  logic [3:0]       flags;
  logic [CNT_W-1:0] retired_cnt;
  logic [CNT_W-1:0] skipped_cnt;
  logic [1:0]       dbg_state;

  int checks   = 0;
  int failures = 0;

  // Expected writebacks {rd, data}
  logic [35:0] exp_q[$];

  // Reference architectural state
  logic [3:0]       m_flags;
  logic [CNT_W-1:0] m_ret;
  logic [CNT_W-1:0] m_skip;

  // wb_ready control
  bit   wb_rand  = 1'b0;
  logic wb_force = 1'b1;

  alu_exec_ctrl #(.CNT_W(CNT_W), .OP_W(OP_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cond     (in_cond),
    .in_op       (in_op),
    .in_s        (in_s),
    .in_rd       (in_rd),
    .in_a        (in_a),
    .in_b        (in_b),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_nzcv    (alu_nzcv),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .flags       (flags),
    .retired_cnt (retired_cnt),
    .skipped_cnt (skipped_cnt),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural ALU: returns {nzcv, result} ----------------
  function automatic logic [35:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic c, v;
    r = 32'd0; c = 1'b0; v = 1'b0; w = 33'd0;
    case (op)
      5'd0, 5'd8: r = a & b;
      5'd1, 5'd9: r = a ^ b;
      5'd2, 5'd10: begin
        r = a - b; c = (a >= b); v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      5'd3: begin
        r = b - a; c = (b >= a); v = (b[31] != a[31]) && (r[31] != b[31]);
      end
      5'd4, 5'd11: begin
        w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      5'd12: r = a | b;
      5'd13: r = b;
      5'd14: r = a & ~b;
      5'd15: r = ~b;
      default: r = 32'd0;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  always_comb {alu_nzcv, alu_result} = alu_f(alu_op, alu_a, alu_b);

  // ---------------- reference condition rules ----------------
  function automatic bit cond_pass(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model step at the moment an instruction is accepted
  task automatic model_accept(input logic [3:0] cond, input logic [4:0] op, input logic s,
                              input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b);
    logic [35:0] res;
    logic [3:0]  nz;
    logic [3:0]  upd;
    bit arith, cmp;
    res   = alu_f(op, a, b);
    nz    = res[35:32];
    arith = (op == 5'd2) || (op == 5'd3) || (op == 5'd4) || (op == 5'd10) || (op == 5'd11);
    cmp   = (op >= 5'd8) && (op <= 5'd11);
    upd   = arith ? nz : {nz[3:2], m_flags[1:0]};
    if (op >= 5'd16 || !cond_pass(cond, m_flags)) begin
      m_skip = m_skip + 1'b1;
    end else if (cmp) begin
      m_flags = upd;
      m_ret   = m_ret + 1'b1;
    end else begin
      exp_q.push_back({rd, res[31:0]});
      if (s) m_flags = upd;
      m_ret = m_ret + 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  logic [3:0]  p_cond;
  logic [4:0]  p_op;
  logic        p_s;
  logic [3:0]  p_rd;
  logic [31:0] p_a, p_b;

  task automatic present(input logic [3:0] cond, input logic [4:0] op, input logic s,
                         input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b);
    p_cond = cond; p_op = op; p_s = s; p_rd = rd; p_a = a; p_b = b;
    in_cond = cond; in_op = op; in_s = s; in_rd = rd; in_a = a; in_b = b;
    in_valid = 1'b1;
  endtask

  // Hold the presented instruction until accepted, then drop in_valid
  task automatic await_accept();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        check("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    model_accept(p_cond, p_op, p_s, p_rd, p_a, p_b);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [3:0] cond, input logic [4:0] op, input logic s,
                       input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    present(cond, op, s, rd, a, b);
    await_accept();
  endtask

  // Wait until the block is idle, then compare architectural state
  task automatic wait_idle_check();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready && !wb_valid) break;
      n++;
      if (n > 200) begin
        check("idle_timeout", 64'd0, 64'd1);
        break;
      end
    end
    check("flags", 64'(flags), 64'(m_flags));
    check("retired_cnt", 64'(retired_cnt), 64'(m_ret));
    check("skipped_cnt", 64'(skipped_cnt), 64'(m_skip));
  endtask

  // ---------------- wb_ready generator ----------------
  always @(posedge clk) begin
    #1;
    wb_ready = wb_rand ? 1'($urandom_range(0, 1)) : wb_force;
  end

  // ---------------- writeback monitor / scoreboard ----------------
  logic        stall_prev = 1'b0;
  logic [35:0] stall_val  = 36'd0;
  logic [35:0] mon_e;

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else if (wb_valid) begin
      if (stall_prev) check("wb_stable", 64'({wb_rd, wb_data}), 64'(stall_val));
      if (wb_ready) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 64'({wb_rd, wb_data}), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wb_rd", 64'(wb_rd), 64'(mon_e[35:32]));
          check("wb_data", 64'(wb_data), 64'(mon_e[31:0]));
        end
        stall_prev = 1'b0;
      end else begin
        stall_prev = 1'b1;
        stall_val  = {wb_rd, wb_data};
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [4:0] op_tab[13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9, 5'd10,
                             5'd11, 5'd12, 5'd13, 5'd14, 5'd15};

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_cond  = 4'd0; in_op = '0; in_s = 1'b0; in_rd = 4'd0; in_a = 32'd0; in_b = 32'd0;
    m_flags  = 4'd0; m_ret = '0; m_skip = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset state
    @(negedge clk);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_retired", 64'(retired_cnt), 64'd0);
    check("rst_skipped", 64'(skipped_cnt), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    // 2: ADD with latency check
    issue(4'he, 5'b00100, 1'b1, 4'd2, 32'd3, 32'd7);
    @(negedge clk);
    check("lat_exec_wb_valid", 64'(wb_valid), 64'd0);
    @(negedge clk);
    check("lat_wb_valid", 64'(wb_valid), 64'd1);
    check("add_wb_rd", 64'(wb_rd), 64'd2);
    check("add_wb_data", 64'(wb_data), 64'd10);
    wait_idle_check();
    check("add_retired", 64'(retired_cnt), 64'd1);

    // 3: CMP equal then MOVEQ
    issue(4'he, 5'b01010, 1'b0, 4'd7, 32'd5, 32'd5);
    wait_idle_check();
    check("cmp_flags", 64'(flags), 64'b0110);
    issue(4'b0000, 5'b01101, 1'b0, 4'd1, 32'd0, 32'd9);
    wait_idle_check();

    // 4: MOVNE is condition-failed
    issue(4'b0001, 5'b01101, 1'b0, 4'd3, 32'd0, 32'd4);
    wait_idle_check();
    check("movne_flags", 64'(flags), 64'b0110);
    check("movne_skipped", 64'(skipped_cnt), 64'd1);

    // 5: writeback stall with a new instruction waiting
    wb_force = 1'b0;
    issue(4'he, 5'b01101, 1'b0, 4'd5, 32'd0, 32'h0000_1234);
    @(posedge clk);
    #1;
    present(4'he, 5'b00010, 1'b0, 4'd6, 32'd100, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_wb_valid", 64'(wb_valid), 64'd1);
      check("stall_wb_data", 64'(wb_data), 64'h1234);
    end
    wb_force = 1'b1;
    await_accept();
    wait_idle_check();

    // 6: ORR keeps C and V, then reset during EXEC
    issue(4'he, 5'b01010, 1'b0, 4'd0, 32'h8000_0000, 32'd1);
    wait_idle_check();
    check("cv_setup_flags", 64'(flags), 64'b0011);
    issue(4'he, 5'b01100, 1'b1, 4'd3, 32'h8000_0000, 32'd0);
    wait_idle_check();
    check("orr_flags", 64'(flags), 64'b1011);
    issue(4'he, 5'b00100, 1'b1, 4'd4, 32'd1, 32'd2);
    reset = 1'b1;
    exp_q.delete();
    m_flags = 4'd0; m_ret = '0; m_skip = '0;
    @(negedge clk);
    check("exec_rst_flags", 64'(flags), 64'd0);
    check("exec_rst_wb_valid", 64'(wb_valid), 64'd0);
    check("exec_rst_state", 64'(dbg_state), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_wb_valid", 64'(wb_valid), 64'd0);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
    end
    wait_idle_check();

    // Random phase
    wb_rand = 1'b1;
    for (int k = 0; k < 80; k++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      int r;
      r = $urandom_range(0, 19);
      if (r < 13) op = op_tab[r];
      else if (r < 16) op = 5'(5 + r - 13);
      else op = 5'($urandom_range(16, 31));
      case ($urandom_range(0, 3))
        0: begin a = 32'($urandom_range(0, 8)); b = 32'($urandom_range(0, 8)); end
        1: begin a = 32'h8000_0000; b = 32'($urandom_range(0, 2)); end
        2: begin a = 32'hFFFF_FFFF; b = 32'($urandom_range(0, 2)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      issue(4'($urandom_range(0, 15)), op, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), a, b);
      if ($urandom_range(0, 1) == 1) wait_idle_check();
    end
    wb_rand = 1'b0;
    wb_force = 1'b1;
    wait_idle_check();
    check("drain_exp_q", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
